// File: rtl/simd_rf_pkg.sv
// Shared types, default sizes and the address-class helper for the SIMD register file.
package simd_rf_pkg;

  localparam int DEF_REG_SIZE     = 8;
  localparam int DEF_REG_QUANTITY = 4;
  localparam int DEF_SEL_BITS     = 4;
  localparam int DEF_VEC_SIZE     = 4;

  typedef logic [DEF_REG_SIZE-1:0]                   lane_t;
  typedef logic [DEF_VEC_SIZE-1:0][DEF_REG_SIZE-1:0] vec_t;

  // Vector registers occupy the bottom of the address space, scalars the rest.
  function automatic logic is_scalar_addr(input int unsigned addr,
                                          input int unsigned reg_quantity);
    return addr >= reg_quantity;
  endfunction

endpackage

// File: rtl/simd_reg_file_if.sv
// Writeback/operand bus of the SIMD register file: one write port, two read ports.
interface simd_reg_file_if #(
  parameter int regSize     = simd_rf_pkg::DEF_REG_SIZE,
  parameter int selBits     = simd_rf_pkg::DEF_SEL_BITS,
  parameter int vecSize     = simd_rf_pkg::DEF_VEC_SIZE
);
  logic                             regWrEnSc;
  logic                             regWrEnVec;
  logic [selBits-1:0]               rSel1;
  logic [selBits-1:0]               rSel2;
  logic [selBits-1:0]               regToWrite;
  logic [vecSize-1:0][regSize-1:0]  dataIn;
  logic [vecSize-1:0][regSize-1:0]  operand1;
  logic [vecSize-1:0][regSize-1:0]  operand2;

  modport master (
    output regWrEnSc, regWrEnVec, rSel1, rSel2, regToWrite, dataIn,
    input  operand1, operand2
  );

  modport slave (
    input  regWrEnSc, regWrEnVec, rSel1, rSel2, regToWrite, dataIn,
    output operand1, operand2
  );
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: address decode, scalar broadcast and, with
// REG_FILE_BYPASS_EN defined, same-cycle forwarding of the write data.
module rf_read_port
  import simd_rf_pkg::*;
#(
  parameter int regSize     = DEF_REG_SIZE,
  parameter int regQuantity = DEF_REG_QUANTITY,
  parameter int selBits     = DEF_SEL_BITS,
  parameter int vecSize     = DEF_VEC_SIZE,
  parameter int scQuantity  = (2**selBits) - regQuantity
) (
  input  logic [selBits-1:0]                                sel,
  input  logic [regQuantity-1:0][vecSize-1:0][regSize-1:0]  vec_bank,
  input  logic [scQuantity-1:0][regSize-1:0]                sc_bank,
  input  logic                                              wr_vec,
  input  logic                                              wr_sc,
  input  logic [selBits-1:0]                                wr_addr,
  input  logic [vecSize-1:0][regSize-1:0]                   wr_data,
  output logic [vecSize-1:0][regSize-1:0]                   operand
);

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    operand = '0;
    for (int i = 0; i < regQuantity; i++)
      if (sel == selBits'(i)) operand = vec_bank[i];
    for (int j = 0; j < scQuantity; j++)
      if (sel == selBits'(regQuantity + j))
        for (int l = 0; l < vecSize; l++) operand[l] = sc_bank[j];
    // wr_vec/wr_sc are already qualified by address class and reset.
    if (wr_vec && wr_addr == sel)
      operand = wr_data;
    else if (wr_sc && wr_addr == sel)
      for (int l = 0; l < vecSize; l++) operand[l] = wr_data[0];
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_vec, wr_sc, wr_addr, wr_data};

  always_comb begin
    operand = '0;
    for (int i = 0; i < regQuantity; i++)
      if (sel == selBits'(i)) operand = vec_bank[i];
    for (int j = 0; j < scQuantity; j++)
      if (sel == selBits'(regQuantity + j))
        for (int l = 0; l < vecSize; l++) operand[l] = sc_bank[j];
  end
`endif

endmodule

// File: rtl/simd_reg_file.sv
// SIMD register file: vector and scalar banks in one address space, two read ports,
// one write port. Optional same-cycle write forwarding via REG_FILE_BYPASS_EN.
module simd_reg_file
  import simd_rf_pkg::*;
#(
  parameter int regSize     = DEF_REG_SIZE,
  parameter int regQuantity = DEF_REG_QUANTITY,
  parameter int selBits     = DEF_SEL_BITS,
  parameter int vecSize     = DEF_VEC_SIZE
) (
  input logic           clk,
  input logic           rst,
  simd_reg_file_if.slave rf
);

  localparam int scQuantity = (2**selBits) - regQuantity;

  logic [regQuantity-1:0][vecSize-1:0][regSize-1:0] vec_bank;
  logic [scQuantity-1:0][regSize-1:0]               sc_bank;

  logic wr_is_sc;
  logic wr_vec;
  logic wr_sc;

  // Mismatched enable/address class is dropped; reset also blocks writes.
  assign wr_is_sc = is_scalar_addr(int'(rf.regToWrite), regQuantity);
  assign wr_vec   = rst && rf.regWrEnVec && !wr_is_sc;
  assign wr_sc    = rst && rf.regWrEnSc  &&  wr_is_sc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_bank <= '0;
      sc_bank  <= '0;
    end else begin
      for (int i = 0; i < regQuantity; i++)
        if (wr_vec && rf.regToWrite == selBits'(i))
          vec_bank[i] <= rf.dataIn;
      for (int j = 0; j < scQuantity; j++)
        if (wr_sc && rf.regToWrite == selBits'(regQuantity + j))
          sc_bank[j] <= rf.dataIn[0];
    end
  end

  rf_read_port #(
    .regSize(regSize), .regQuantity(regQuantity),
    .selBits(selBits), .vecSize(vecSize)
  ) u_port1 (
    .sel(rf.rSel1), .vec_bank(vec_bank), .sc_bank(sc_bank),
    .wr_vec(wr_vec), .wr_sc(wr_sc), .wr_addr(rf.regToWrite),
    .wr_data(rf.dataIn), .operand(rf.operand1)
  );

  rf_read_port #(
    .regSize(regSize), .regQuantity(regQuantity),
    .selBits(selBits), .vecSize(vecSize)
  ) u_port2 (
    .sel(rf.rSel2), .vec_bank(vec_bank), .sc_bank(sc_bank),
    .wr_vec(wr_vec), .wr_sc(wr_sc), .wr_addr(rf.regToWrite),
    .wr_data(rf.dataIn), .operand(rf.operand2)
  );

endmodule

// File: tb/tb_simd_reg_file.sv
// Directed, table-driven bench for simd_reg_file with default sizes (4 lanes x 8 bits).
module tb_simd_reg_file;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  simd_reg_file_if #(.regSize(8), .selBits(4), .vecSize(4)) rf ();

  simd_reg_file #(.regSize(8), .regQuantity(4), .selBits(4), .vecSize(4)) dut (
    .clk(clk), .rst(rst), .rf(rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en_sc;
    logic        en_vec;
    logic [3:0]  wr_addr;
    logic [31:0] data;
    logic [3:0]  sel1;
    logic [3:0]  sel2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_rec_t;

  vec_rec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic sc, input logic vc, input logic [3:0] wa,
                     input logic [31:0] d, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [31:0] e1, input logic [31:0] e2);
    vec_rec_t r;
    r.name = nm; r.en_sc = sc; r.en_vec = vc; r.wr_addr = wa; r.data = d;
    r.sel1 = s1; r.sel2 = s2; r.exp1 = e1; r.exp2 = e2;
    tbl.push_back(r);
  endtask

  task automatic idle();
    rf.regWrEnSc  = 1'b0;
    rf.regWrEnVec = 1'b0;
    rf.regToWrite = '0;
    rf.dataIn     = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    idle();
    rf.rSel1 = 4'd0;
    rf.rSel2 = 4'd4;

    // Each row: optional write over one edge, then read both ports afterwards.
    add("sc_wr4",     1, 0, 4'd4,  32'h0000_0004, 4'd4,  4'd1,  32'h0404_0404, 32'h0);
    add("v0_clean",   0, 0, 4'd0,  32'h0,         4'd0,  4'd4,  32'h0,         32'h0404_0404);
    add("vec_wr3",    0, 1, 4'd3,  32'hDEAD_BEEF, 4'd3,  4'd7,  32'hDEAD_BEEF, 32'h0);
    add("dual_read",  0, 0, 4'd0,  32'h0,         4'd4,  4'd3,  32'h0404_0404, 32'hDEAD_BEEF);
    add("spec12",     0, 0, 4'd0,  32'h0,         4'd12, 4'd12, 32'h0,         32'h0);
    add("sc_wr13",    1, 0, 4'd13, 32'h1122_3307, 4'd13, 4'd12, 32'h0707_0707, 32'h0);
    add("sc_wr14",    1, 0, 4'd14, 32'h0000_0009, 4'd14, 4'd13, 32'h0909_0909, 32'h0707_0707);
    add("vec_to_sc5", 0, 1, 4'd5,  32'hAABB_CCDD, 4'd5,  4'd4,  32'h0,         32'h0404_0404);
    add("sc_to_v2",   1, 0, 4'd2,  32'h0000_0055, 4'd2,  4'd3,  32'h0,         32'hDEAD_BEEF);
    add("both_sc6",   1, 1, 4'd6,  32'h1234_5678, 4'd6,  4'd0,  32'h7878_7878, 32'h0);
    add("both_v1",    1, 1, 4'd1,  32'hCAFE_F00D, 4'd1,  4'd6,  32'hCAFE_F00D, 32'h7878_7878);
    add("vec_wr0",    0, 1, 4'd0,  32'h0102_0304, 4'd0,  4'd15, 32'h0102_0304, 32'h0);
    add("sc_wr15",    1, 0, 4'd15, 32'h0000_00FF, 4'd15, 4'd4,  32'hFFFF_FFFF, 32'h0404_0404);

    // Reset state across a few addresses.
    #2;
    check("rst_a0", rf.operand1, 32'h0);
    check("rst_a4", rf.operand2, 32'h0);
    rf.rSel1 = 4'd12;
    rf.rSel2 = 4'd3;
    #1;
    check("rst_a12", rf.operand1, 32'h0);
    check("rst_a3",  rf.operand2, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      rf.regWrEnSc  = tbl[k].en_sc;
      rf.regWrEnVec = tbl[k].en_vec;
      rf.regToWrite = tbl[k].wr_addr;
      rf.dataIn     = tbl[k].data;
      rf.rSel1      = tbl[k].sel1;
      rf.rSel2      = tbl[k].sel2;
      @(posedge clk);
      #1;
      idle();
      #1;
      check({tbl[k].name, "_p1"}, rf.operand1, tbl[k].exp1);
      check({tbl[k].name, "_p2"}, rf.operand2, tbl[k].exp2);
    end

    // Read of a register being written in the same cycle.
    @(negedge clk);
    rf.regWrEnVec = 1'b1;
    rf.regToWrite = 4'd3;
    rf.dataIn     = 32'h1111_1111;
    rf.rSel1      = 4'd3;
    rf.rSel2      = 4'd4;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("raw_same_cycle", rf.operand1, 32'h1111_1111);
`else
    check("raw_same_cycle", rf.operand1, 32'hDEAD_BEEF);
`endif
    check("raw_other_port", rf.operand2, 32'h0404_0404);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("raw_after_edge", rf.operand1, 32'h1111_1111);

    // Reset asserted mid-cycle with a write pending: immediate clear, write dropped.
    @(negedge clk);
    rf.regWrEnSc  = 1'b1;
    rf.regToWrite = 4'd13;
    rf.dataIn     = 32'h0000_0033;
    rf.rSel1      = 4'd3;
    rf.rSel2      = 4'd13;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_v3",  rf.operand1, 32'h0);
    check("midrst_s9",  rf.operand2, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_edge", rf.operand2, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    check("post_rst_s9", rf.operand2, 32'h0);

    // First edge after release accepts a write.
    rf.regWrEnVec = 1'b1;
    rf.regToWrite = 4'd2;
    rf.dataIn     = 32'hA5A5_5A5A;
    rf.rSel1      = 4'd2;
    @(posedge clk);
    #1;
    idle();
    #1;
    check("first_wr_v2", rf.operand1, 32'hA5A5_5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
